// File: rtl/result_collector_pkg.sv
// Shared constants for the scaler / result collector datapath.
// It also holds the FIFO pointer-width helper.
package result_collector_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int INDEX_WIDTH_DEF = 18;
  localparam int CELL_AMOUNT_DEF = 2;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int ROW_WIDTH_DEF   = CELL_AMOUNT_DEF * DATA_WIDTH_DEF;

  // One extra bit beyond the address lets full and empty be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_collector_row_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push into a full FIFO is accepted only when a pop happens on the same edge.
// dout reads as zero while the FIFO is empty.
module row_fifo
  import result_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/result_collector.sv
// Collects scaler elements into packed rows and queues them for the result writer.
// The scaler cannot be stalled, so dropped rows and out-of-order indices are flagged instead.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int CELL_AMOUNT = CELL_AMOUNT_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INDEX_WIDTH-1:0]          in_index,
  input  logic [DATA_WIDTH-1:0]           in_value,
  input  logic                            in_enable,
  output logic [CELL_AMOUNT*DATA_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [15:0]                     row_count,
  output logic                            seq_error,
  output logic                            overflow
);

  localparam int ROW_W = CELL_AMOUNT * DATA_WIDTH;
  localparam int EW    = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  localparam logic [EW-1:0] LAST_IDX = EW'(CELL_AMOUNT - 1);
  localparam logic [EW-1:0] SECOND_IDX = (CELL_AMOUNT > 1) ? EW'(1) : '0;

  logic [EW-1:0]                           expected_q, expected_d;
  logic [CELL_AMOUNT-1:0][DATA_WIDTH-1:0]  slots_q, slots_d;
  logic [15:0]                             row_count_q, row_count_d;
  logic                                    seq_error_q, seq_error_d;
  logic                                    overflow_q, overflow_d;

  logic             hit, last, complete, restart;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ROW_W-1:0] row_word;

  always_comb begin
    hit      = in_enable && (in_index == INDEX_WIDTH'(expected_q));
    last     = (expected_q == LAST_IDX);
    complete = hit && last;
    restart  = in_enable && !hit && (in_index == '0);
    fifo_pop  = !fifo_empty && out_ready;
    fifo_push = complete && (!fifo_full || fifo_pop);
    // The final element bypasses the slot register so the row is pushed on its own edge.
    row_word = slots_q;
    row_word[ROW_W-1 -: DATA_WIDTH] = in_value;
  end

  always_comb begin
    expected_d  = expected_q;
    slots_d     = slots_q;
    row_count_d = row_count_q;
    seq_error_d = seq_error_q;
    overflow_d  = overflow_q;
    if (hit) begin
      slots_d[expected_q] = in_value;
      expected_d = last ? '0 : expected_q + 1'b1;
    end else if (in_enable) begin
      seq_error_d = 1'b1;
      slots_d     = '0;
      if (restart) begin
        slots_d[0] = in_value;
        expected_d = SECOND_IDX;
      end else begin
        expected_d = '0;
      end
    end
    if (fifo_push) row_count_d = row_count_q + 16'd1;
    if (complete && !fifo_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q  <= '0;
      slots_q     <= '0;
      row_count_q <= '0;
      seq_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      slots_q     <= slots_d;
      row_count_q <= row_count_d;
      seq_error_q <= seq_error_d;
      overflow_q  <= overflow_d;
    end
  end

  row_fifo #(
    .WIDTH(ROW_W),
    .DEPTH(FIFO_DEPTH)
  ) u_row_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (row_word),
    .dout (out_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign row_count = row_count_q;
  assign seq_error = seq_error_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_result_collector;

  localparam int DW = 16;
  localparam int IW = 18;
  localparam int CA = 2;
  localparam int FD = 4;
  localparam int RW = CA * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] in_index;
  logic [DW-1:0] in_value;
  logic          in_enable;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   row_count;
  logic          seq_error;
  logic          overflow;

  result_collector #(
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW),
    .CELL_AMOUNT(CA),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_index (in_index),
    .in_value (in_value),
    .in_enable(in_enable),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .row_count(row_count),
    .seq_error(seq_error),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          r;
    bit          en;
    int          idx;
    logic [15:0] val;
    bit          rdy;
    bit          v;
    logic [31:0] d;
    int          rc;
    bit          seq;
    bit          ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit en, int idx, logic [15:0] val, bit rdy,
                              bit v, logic [31:0] d, int rc, bit seq, bit ovf);
    vec_t t;
    t.r = r; t.en = en; t.idx = idx; t.val = val; t.rdy = rdy;
    t.v = v; t.d = d; t.rc = rc; t.seq = seq; t.ovf = ovf;
    vecs.push_back(t);
  endfunction

  // Reference model: rows as a bounded queue, partial row as an element array.
  int            m_exp;
  logic [DW-1:0] m_part [CA];
  logic [RW-1:0] m_q [$];
  int            m_rc;
  bit            m_seq, m_ovf;

  function automatic void model_step(bit r, bit en, int idx, logic [DW-1:0] val, bit rdy);
    bit            pop, have_row;
    logic [RW-1:0] row;
    if (r) begin
      m_exp = 0; m_q.delete(); m_rc = 0; m_seq = 0; m_ovf = 0;
      foreach (m_part[k]) m_part[k] = '0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    have_row = 0;
    row = '0;
    if (en) begin
      if (idx == m_exp) begin
        m_part[idx] = val;
        if (m_exp == CA - 1) begin
          have_row = 1;
          m_exp = 0;
        end else begin
          m_exp = m_exp + 1;
        end
      end else begin
        m_seq = 1;
        foreach (m_part[k]) m_part[k] = '0;
        if (idx == 0) begin
          m_part[0] = val;
          m_exp = 1;
        end else begin
          m_exp = 0;
        end
      end
    end
    if (have_row) for (int k = 0; k < CA; k++) row[k*DW +: DW] = m_part[k];
    if (pop) void'(m_q.pop_front());
    if (have_row) begin
      if (m_q.size() < FD) begin
        m_q.push_back(row);
        m_rc = (m_rc + 1) % 65536;
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  task automatic cycle(bit r, bit en, int idx, logic [DW-1:0] val, bit rdy);
    rst       = r;
    in_enable = en;
    in_index  = IW'(idx);
    in_value  = val;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Basic row
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,5,1, 0,32'h0,0,0,0);
    add(0,1,1,35,1, 1,32'h0023_0005,1,0,0);
    add(0,0,0,0,1, 0,32'h0,1,0,0);
    // Gaps
    add(0,1,0,10,1, 0,32'h0,1,0,0);
    add(0,0,0,0,1, 0,32'h0,1,0,0);
    add(0,0,1,77,1, 0,32'h0,1,0,0);
    add(0,0,0,0,1, 0,32'h0,1,0,0);
    add(0,1,1,25,1, 1,32'h0019_000A,2,0,0);
    add(0,0,0,0,1, 0,32'h0,2,0,0);
    // Sequence error with restart, then wrong first index
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,7,1, 0,32'h0,0,0,0);
    add(0,1,0,9,1, 0,32'h0,0,1,0);
    add(0,1,1,11,1, 1,32'h000B_0009,1,1,0);
    add(0,0,0,0,1, 0,32'h0,1,1,0);
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,1,3,1, 0,32'h0,0,1,0);
    add(0,0,0,0,1, 0,32'h0,0,1,0);
    // Reset mid-row
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,4,1, 0,32'h0,0,0,0);
    add(1,0,0,0,1, 0,32'h0,0,0,0);
    add(0,1,1,6,1, 0,32'h0,0,1,0);
    add(0,1,0,1,1, 0,32'h0,0,1,0);
    add(0,1,1,2,1, 1,32'h0002_0001,1,1,0);
    add(0,0,0,0,1, 0,32'h0,1,1,0);
    // Backpressure and overflow
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,1,0, 0,32'h0,0,0,0);
    add(0,1,1,2,0, 1,32'h0002_0001,1,0,0);
    add(0,1,0,3,0, 1,32'h0002_0001,1,0,0);
    add(0,1,1,4,0, 1,32'h0002_0001,2,0,0);
    add(0,1,0,5,0, 1,32'h0002_0001,2,0,0);
    add(0,1,1,6,0, 1,32'h0002_0001,3,0,0);
    add(0,1,0,7,0, 1,32'h0002_0001,3,0,0);
    add(0,1,1,8,0, 1,32'h0002_0001,4,0,0);
    add(0,1,0,9,0, 1,32'h0002_0001,4,0,0);
    add(0,1,1,10,0, 1,32'h0002_0001,4,0,1);
    add(0,0,0,0,0, 1,32'h0002_0001,4,0,1);
    add(0,0,0,0,1, 1,32'h0004_0003,4,0,1);
    add(0,0,0,0,1, 1,32'h0006_0005,4,0,1);
    add(0,0,0,0,1, 1,32'h0008_0007,4,0,1);
    add(0,0,0,0,1, 0,32'h0,4,0,1);
    // Push and pop on the same edge with the FIFO full
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,16'h11,0, 0,32'h0,0,0,0);
    add(0,1,1,16'h12,0, 1,32'h0012_0011,1,0,0);
    add(0,1,0,16'h21,0, 1,32'h0012_0011,1,0,0);
    add(0,1,1,16'h22,0, 1,32'h0012_0011,2,0,0);
    add(0,1,0,16'h31,0, 1,32'h0012_0011,2,0,0);
    add(0,1,1,16'h32,0, 1,32'h0012_0011,3,0,0);
    add(0,1,0,16'h41,0, 1,32'h0012_0011,3,0,0);
    add(0,1,1,16'h42,0, 1,32'h0012_0011,4,0,0);
    add(0,1,0,16'h51,0, 1,32'h0012_0011,4,0,0);
    add(0,1,1,16'h52,1, 1,32'h0022_0021,5,0,0);
    add(0,0,0,0,1, 1,32'h0032_0031,5,0,0);
    add(0,0,0,0,1, 1,32'h0042_0041,5,0,0);
    add(0,0,0,0,1, 1,32'h0052_0051,5,0,0);
    add(0,0,0,0,1, 0,32'h0,5,0,0);

    rst = 1'b1; in_enable = 1'b0; in_index = '0; in_value = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].en, vecs[i].idx, vecs[i].val, vecs[i].rdy);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].v));
      chk($sformatf("vec%0d out_data", i),  64'(out_data),  64'(vecs[i].d));
      chk($sformatf("vec%0d row_count", i), 64'(row_count), 64'(vecs[i].rc));
      chk($sformatf("vec%0d seq_error", i), 64'(seq_error), 64'(vecs[i].seq));
      chk($sformatf("vec%0d overflow", i),  64'(overflow),  64'(vecs[i].ovf));
    end

    // Randomized traffic with phases of varying downstream readiness.
    model_step(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    begin
      int rdy_pct;
      rdy_pct = 50;
      for (int n = 0; n < 4000; n++) begin
        bit            r, en, rdy;
        int            idx;
        logic [DW-1:0] val;
        if (n % 250 == 0) rdy_pct = $urandom_range(0, 100);
        r   = ($urandom_range(0, 399) == 0);
        en  = ($urandom_range(0, 3) != 0);
        idx = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, 3));
        val = DW'($urandom);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        model_step(r, en, idx, val, rdy);
        cycle(r, en, idx, val, rdy);
        chk($sformatf("rnd%0d out_valid", n), 64'(out_valid), 64'(m_q.size() > 0));
        chk($sformatf("rnd%0d out_data", n),  64'(out_data),  (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
        chk($sformatf("rnd%0d row_count", n), 64'(row_count), 64'(m_rc));
        chk($sformatf("rnd%0d seq_error", n), 64'(seq_error), 64'(m_seq));
        chk($sformatf("rnd%0d overflow", n),  64'(overflow),  64'(m_ovf));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
